// File: rtl/mac_sequencer.sv
// mac_sequencer: steps one MAC lane through clear, INPUTS accumulates, a bias add,
// optional ReLU, then hands the neuron result downstream over valid/ready.
module mac_sequencer #(
  parameter int n      = 8,
  parameter int m      = 4,
  parameter int INPUTS = 4,
  parameter int ADDR_W = 2,
  parameter int RELU   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mac_clk_en,
  output logic              mac_ctrl_rst,
  output logic              mac_use_bias,
  input  logic [n-1:0]      mac_sum,
  output logic [n-1:0]      result,
  output logic              valid,
  input  logic              ready
);

  typedef enum logic [2:0] {IDLE, CLEAR, ACC, BIAS, OUT} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(INPUTS - 1);

  if (m < 0 || m >= n || INPUTS < 1 || ADDR_W < 1 || (2 ** ADDR_W) < INPUTS) begin : g_param_check
    $error("mac_sequencer: illegal parameter combination");
  end

  state_t            state, state_nx;
  logic [ADDR_W-1:0] k;
  logic [n-1:0]      act;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLEAR;
      CLEAR:   state_nx = ACC;
      ACC:     if (k == LAST) state_nx = BIAS;
      BIAS:    state_nx = OUT;
      OUT:     if (ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address runs one element ahead of k so each read lands the cycle its product accumulates.
  always_comb begin
    busy         = (state != IDLE);
    mem_addr     = '0;
    mem_rd       = 1'b0;
    mac_clk_en   = 1'b0;
    mac_ctrl_rst = 1'b0;
    mac_use_bias = 1'b0;
    valid        = 1'b0;
    case (state)
      CLEAR: begin
        mac_ctrl_rst = 1'b1;
        mem_rd       = 1'b1;
      end
      ACC: begin
        mac_clk_en = 1'b1;
        if (k != LAST) begin
          mem_rd   = 1'b1;
          mem_addr = k + 1'b1;
        end else begin
          mem_addr = k;
        end
      end
      BIAS: begin
        mac_use_bias = 1'b1;
        mac_clk_en   = 1'b1;
      end
      OUT:     valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    act = mac_sum;
    if (RELU != 0 && mac_sum[n-1]) act = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k      <= '0;
      result <= '0;
    end else begin
      if (state == ACC && k != LAST) k <= k + 1'b1;
      else                           k <= '0;
      if (state == BIAS) result <= act;
    end
  end

endmodule
